// File: rtl/i2c_tx_feeder_pkg.sv
// i2c_tx_feeder_pkg: shared FSM states and bus constants for the i2c command stage
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, XFER, FINISH} state_t;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ = 1'b1;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
endpackage

// File: rtl/i2c_tx_feeder_if.sv
// i2c_tx_feeder_if: command/data link between the feeder and the i2c_master engine
interface i2c_tx_feeder_if #(parameter int LEN_W = 4);
  import i2c_pkg::*;
  logic start;
  logic [LEN_W-1:0] byte_no;
  logic rd_wr;
  logic [I2C_ADDR_W-1:0] slave_addr;
  logic [I2C_DATA_W-1:0] data_in;
  logic ack_wstrobe;
  logic busy;
  logic done;
  logic [I2C_DATA_W-1:0] data_out;
  modport master (output start, byte_no, rd_wr, slave_addr, data_in, input ack_wstrobe, busy, done, data_out);
  modport slave (input start, byte_no, rd_wr, slave_addr, data_in, output ack_wstrobe, busy, done, data_out);
endinterface

// File: rtl/i2c_byte_fifo.sv
// i2c_byte_fifo: circular byte FIFO with explicit level counter and overflow pulse
module i2c_byte_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [I2C_DATA_W-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic [LW-1:0]         level,
  output logic [I2C_DATA_W-1:0] head
);
  logic [I2C_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= push && full;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/i2c_tx_feeder.sv
// i2c_tx_feeder: buffers host write bytes and sequences one i2c_master transaction per go
module i2c_tx_feeder
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [I2C_DATA_W-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  input  logic                    go,
  input  logic                    go_rd_wr,
  input  logic [I2C_ADDR_W-1:0]   go_addr,
  input  logic [LEN_W-1:0]        go_len,
  output logic                    xfer_busy,
  output logic                    xfer_done,
  output logic                    err,
  output logic                    rx_valid,
  output logic [I2C_DATA_W-1:0]   rx_data,
  i2c_tx_feeder_if.master         bus
);
  state_t state, next;
  logic ack_q, ack_rise, take, reject, accept;
  logic [LEN_W-1:0] ack_cnt;
  assign ack_rise = bus.ack_wstrobe && !ack_q;
  assign take = state == XFER && ack_rise && ack_cnt < bus.byte_no;
  assign reject = go_len == '0 || (go_rd_wr == I2C_WRITE && int'(level) < int'(go_len));
  assign accept = state == IDLE && go && !reject;
  i2c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_en), .pop(take && bus.rd_wr == I2C_WRITE),
    .wr_data(wr_data), .full(full), .empty(empty), .ovf(ovf), .level(level), .head(bus.data_in)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = accept ? LAUNCH : IDLE;
      LAUNCH:    next = WAIT_BUSY;
      WAIT_BUSY: next = bus.busy ? XFER : WAIT_BUSY;
      XFER:      next = bus.done ? FINISH : XFER;
      default:   next = IDLE;
    endcase
    bus.start = state == LAUNCH;
    xfer_done = state == FINISH;
    xfer_busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ack_q <= 1'b0;
      ack_cnt <= '0;
      bus.byte_no <= '0;
      bus.rd_wr <= I2C_WRITE;
      bus.slave_addr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= next;
      ack_q <= bus.ack_wstrobe;
      err <= state == IDLE && go && reject;
      rx_valid <= take && bus.rd_wr == I2C_READ;
      if (take && bus.rd_wr == I2C_READ) rx_data <= bus.data_out;
      if (accept) begin
        bus.byte_no <= go_len;
        bus.rd_wr <= go_rd_wr;
        bus.slave_addr <= go_addr;
        ack_cnt <= '0;
      end else if (take) ack_cnt <= ack_cnt + 1'b1;
    end
endmodule

// File: tb/tb_i2c_tx_feeder.sv
// tb_i2c_tx_feeder: directed self-checking bench for i2c_tx_feeder with a hand-driven master
module tb_i2c_tx_feeder;
  import i2c_pkg::*;
  logic clk = 0, reset = 0, wr_en = 0, go = 0, go_rd_wr = 0;
  logic [7:0] wr_data = 0;
  logic [6:0] go_addr = 0;
  logic [3:0] go_len = 0;
  logic full, empty, ovf, xfer_busy, xfer_done, err, rx_valid;
  logic [3:0] level;
  logic [7:0] rx_data;
  int n_checks = 0, n_fail = 0;
  i2c_tx_feeder_if #(.LEN_W(4)) bus();
  i2c_tx_feeder #(.DEPTH(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .ovf(ovf), .go(go), .go_rd_wr(go_rd_wr), .go_addr(go_addr), .go_len(go_len),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .err(err), .rx_valid(rx_valid),
    .rx_data(rx_data), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d; step(); wr_en = 0;
  endtask
  task automatic do_reset;
    reset = 0; go = 0; wr_en = 0;
    bus.ack_wstrobe = 0; bus.busy = 0; bus.done = 0; bus.data_out = 0;
    step(); step(); reset = 1; step();
  endtask
  task automatic launch(input logic rw, input logic [6:0] a, input logic [3:0] len);
    go = 1; go_rd_wr = rw; go_addr = a; go_len = len; step();
    go = 0; step();
    bus.busy = 1; step();
  endtask
  task automatic ack;
    bus.ack_wstrobe = 1; step(); bus.ack_wstrobe = 0; step();
  endtask
  task automatic finish;
    bus.done = 1; bus.busy = 0; step(); bus.done = 0; step();
  endtask
  task automatic test_reset;
    bus.ack_wstrobe = 0; bus.busy = 0; bus.done = 0; bus.data_out = 0;
    step(); step();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", full); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level); end
    n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b exp 0", bus.start); end
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rst_xfer_busy got %b exp 0", xfer_busy); end
    n_checks++; if (bus.byte_no !== 4'd0) begin n_fail++; $display("FAIL rst_byte_no got %0d exp 0", bus.byte_no); end
    n_checks++; if (bus.slave_addr !== 7'd0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", bus.slave_addr); end
    n_checks++; if (rx_data !== 8'd0) begin n_fail++; $display("FAIL rst_rx_data got %h exp 0", rx_data); end
    n_checks++; if (bus.data_in !== 8'd0) begin n_fail++; $display("FAIL rst_data_in got %h exp 0", bus.data_in); end
    reset = 1; step();
  endtask
  task automatic test_write3;
    push(8'hAA); push(8'hBB); push(8'hCC);
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL wr_level3 got %0d exp 3", level); end
    n_checks++; if (bus.data_in !== 8'hAA) begin n_fail++; $display("FAIL wr_head0 got %h exp aa", bus.data_in); end
    go = 1; go_rd_wr = 0; go_addr = 7'h42; go_len = 4'd3; step(); go = 0;
    n_checks++; if (bus.start !== 1'b1) begin n_fail++; $display("FAIL wr_start got %b exp 1", bus.start); end
    n_checks++; if (bus.slave_addr !== 7'h42) begin n_fail++; $display("FAIL wr_addr got %h exp 42", bus.slave_addr); end
    n_checks++; if (bus.byte_no !== 4'd3) begin n_fail++; $display("FAIL wr_byte_no got %0d exp 3", bus.byte_no); end
    n_checks++; if (bus.rd_wr !== I2C_WRITE) begin n_fail++; $display("FAIL wr_rd_wr got %b exp 0", bus.rd_wr); end
    n_checks++; if (xfer_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got %b exp 1", xfer_busy); end
    step();
    n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL wr_start_once got %b exp 0", bus.start); end
    bus.busy = 1; step();
    ack();
    n_checks++; if (bus.data_in !== 8'hBB) begin n_fail++; $display("FAIL wr_head1 got %h exp bb", bus.data_in); end
    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL wr_level2 got %0d exp 2", level); end
    ack();
    n_checks++; if (bus.data_in !== 8'hCC) begin n_fail++; $display("FAIL wr_head2 got %h exp cc", bus.data_in); end
    ack();
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL wr_level0 got %0d exp 0", level); end
    n_checks++; if (bus.data_in !== 8'h00) begin n_fail++; $display("FAIL wr_head_empty got %h exp 00", bus.data_in); end
    bus.done = 1; bus.busy = 0; step();
    n_checks++; if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL wr_done got %b exp 1", xfer_done); end
    bus.done = 0; step();
    n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse got %b exp 0", xfer_done); end
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end got %b exp 0", xfer_busy); end
    n_checks++; if (bus.slave_addr !== 7'h42) begin n_fail++; $display("FAIL wr_addr_hold got %h exp 42", bus.slave_addr); end
  endtask
  task automatic test_read3;
    logic [7:0] rx_exp [3];
    rx_exp[0] = 8'hDE; rx_exp[1] = 8'hAD; rx_exp[2] = 8'hBE;
    do_reset();
    push(8'h55);
    launch(1'b1, 7'h15, 4'd3);
    n_checks++; if (bus.rd_wr !== I2C_READ) begin n_fail++; $display("FAIL rd_rd_wr got %b exp 1", bus.rd_wr); end
    for (int i = 0; i < 3; i++) begin
      bus.data_out = rx_exp[i]; bus.ack_wstrobe = 1; step();
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid%0d got %b exp 1", i, rx_valid); end
      n_checks++; if (rx_data !== rx_exp[i]) begin n_fail++; $display("FAIL rd_data%0d got %h exp %h", i, rx_data, rx_exp[i]); end
      bus.ack_wstrobe = 0; step();
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse%0d got %b exp 0", i, rx_valid); end
    end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL rd_fifo_level got %0d exp 1", level); end
    n_checks++; if (bus.data_in !== 8'h55) begin n_fail++; $display("FAIL rd_fifo_head got %h exp 55", bus.data_in); end
    bus.done = 1; bus.busy = 0; step();
    n_checks++; if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL rd_done got %b exp 1", xfer_done); end
    bus.done = 0; step();
  endtask
  task automatic test_overflow;
    do_reset();
    for (int i = 1; i <= 7; i++) push(8'(i));
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_full7 got %b exp 0", full); end
    push(8'h08);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full8 got %b exp 1", full); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", ovf); end
    wr_en = 1; wr_data = 8'h09; step(); wr_en = 0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b exp 1", ovf); end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d exp 8", level); end
    step();
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b exp 0", ovf); end
    launch(1'b0, 7'h10, 4'd8);
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (bus.data_in !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d got %h exp %h", i, bus.data_in, 8'(i)); end
      ack();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b exp 1", empty); end
    finish();
  endtask
  task automatic test_reject;
    do_reset();
    push(8'h01); push(8'h02);
    go = 1; go_rd_wr = 0; go_addr = 7'h11; go_len = 4'd4; step(); go = 0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_short_err got %b exp 1", err); end
    n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL rej_start got %b exp 0", bus.start); end
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rej_busy got %b exp 0", xfer_busy); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rej_err_pulse got %b exp 0", err); end
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rej_busy2 got %b exp 0", xfer_busy); end
    go = 1; go_rd_wr = 1; go_len = 4'd0; step(); go = 0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_len0_err got %b exp 1", err); end
    step();
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rej_len0_busy got %b exp 0", xfer_busy); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    launch(1'b0, 7'h33, 4'd3);
    bus.ack_wstrobe = 1; wr_en = 1; wr_data = 8'h44; step(); wr_en = 0;
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL cc_level got %0d exp 3", level); end
    n_checks++; if (bus.data_in !== 8'h22) begin n_fail++; $display("FAIL cc_head got %h exp 22", bus.data_in); end
    step(); step();
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL cc_held_level got %0d exp 3", level); end
    bus.ack_wstrobe = 0; step();
    ack();
    n_checks++; if (bus.data_in !== 8'h33) begin n_fail++; $display("FAIL cc_head2 got %h exp 33", bus.data_in); end
    ack();
    n_checks++; if (bus.data_in !== 8'h44) begin n_fail++; $display("FAIL cc_head3 got %h exp 44", bus.data_in); end
    ack();
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL cc_excess_level got %0d exp 1", level); end
    n_checks++; if (bus.data_in !== 8'h44) begin n_fail++; $display("FAIL cc_excess_head got %h exp 44", bus.data_in); end
    go = 1; go_rd_wr = 0; go_len = 4'd1; step(); go = 0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL cc_go_ignored got %b exp 0", err); end
    finish();
  endtask
  task automatic test_reset_mid;
    do_reset();
    push(8'hAA); push(8'hBB); push(8'hCC);
    launch(1'b0, 7'h42, 4'd3);
    ack();
    n_checks++; if (level !== 4'd2) begin n_fail++; $display("FAIL rm_level got %0d exp 2", level); end
    reset = 0; #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rm_empty got %b exp 1", empty); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rm_level0 got %0d exp 0", level); end
    n_checks++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b exp 0", xfer_busy); end
    n_checks++; if (bus.byte_no !== 4'd0) begin n_fail++; $display("FAIL rm_byte_no got %0d exp 0", bus.byte_no); end
    n_checks++; if (bus.slave_addr !== 7'd0) begin n_fail++; $display("FAIL rm_addr got %h exp 0", bus.slave_addr); end
    n_checks++; if (bus.data_in !== 8'd0) begin n_fail++; $display("FAIL rm_data_in got %h exp 0", bus.data_in); end
    bus.busy = 0; bus.ack_wstrobe = 0;
    step();
    n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done got %b exp 0", xfer_done); end
    reset = 1; step();
    n_checks++; if (xfer_done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done2 got %b exp 0", xfer_done); end
    push(8'h66); push(8'h77);
    launch(1'b0, 7'h21, 4'd2);
    n_checks++; if (bus.data_in !== 8'h66) begin n_fail++; $display("FAIL rm_head got %h exp 66", bus.data_in); end
    ack(); ack();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rm_drained got %b exp 1", empty); end
    bus.done = 1; bus.busy = 0; step();
    n_checks++; if (xfer_done !== 1'b1) begin n_fail++; $display("FAIL rm_done got %b exp 1", xfer_done); end
    bus.done = 0; step();
  endtask
  initial begin
    test_reset();
    test_write3();
    test_read3();
    test_overflow();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
